adc_uart_tx: RTL and testbench

Downstream consumer of the DAC/ADC conversion stage. On each end-of-conversion pulse it captures the 12-bit ADC result and sends it to the host PC over UART (8N1, LSB first) as a two-byte frame. Frame format: header nibble plus data MSBs, then data LSBs. It flags any sample that arrives while a frame is still in flight.

---
 rtl/adc_uart_tx.sv | 128 ++++++++++++
 tb/tb_adc_uart_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_uart_tx.sv
// ADC result to UART bridge: captures a 12-bit sample on eoconv_i and sends it
// as two 8N1 bytes, {HDR, din[11:8]} then din[7:0], flagging samples that arrive mid-frame.
module adc_uart_tx #(
    parameter int          CLK_DIV = 868,
    parameter logic [3:0]  HDR     = 4'hA
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        eoconv_i,
    input  logic [11:0] din_i,
    input  logic        clr_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        eotx_o,
    output logic        ovr_o
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic          byte_idx, byte_nxt;
    logic [15:0]   hold, hold_nxt;
    logic          tx_nxt, busy_nxt, eotx_nxt, ovr_nxt;
    logic [7:0]    byte_sel;
    logic          last;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= 1'b0;
            hold     <= '0;
            tx_o     <= 1'b1;
            busy_o   <= 1'b0;
            eotx_o   <= 1'b0;
            ovr_o    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_idx  <= bit_nxt;
            byte_idx <= byte_nxt;
            hold     <= hold_nxt;
            tx_o     <= tx_nxt;
            busy_o   <= busy_nxt;
            eotx_o   <= eotx_nxt;
            ovr_o    <= ovr_nxt;
        end
    end

    assign last = (cnt == LAST);

    // NOTE: every signal driven here gets a default first, which keeps the
    // block purely combinational (no latches) whatever branch is taken.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        byte_nxt  = byte_idx;
        hold_nxt  = hold;
        eotx_nxt  = 1'b0;
        ovr_nxt   = ovr_o & ~clr_i;

        unique case (state)
            IDLE: begin
                if (eoconv_i) begin
                    hold_nxt  = {HDR, din_i};
                    byte_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (last) begin
                    cnt_nxt   = '0;
                    bit_nxt   = 3'd0;
                    state_nxt = DATA;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DATA: begin
                if (last) begin
                    cnt_nxt = '0;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                    else                 bit_nxt   = bit_idx + 3'd1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STOP: begin
                if (last) begin
                    cnt_nxt = '0;
                    if (!byte_idx) begin
                        byte_nxt  = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                        eotx_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A sample arriving mid-frame is dropped; set beats a simultaneous clear.
        if (state != IDLE && eoconv_i) ovr_nxt = 1'b1;

        // Outputs are registered, so they are derived from the next-state values.
        byte_sel = byte_nxt ? hold_nxt[7:0] : hold_nxt[15:8];
        busy_nxt = (state_nxt != IDLE);
        unique case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = byte_sel[bit_nxt];
            default: tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_adc_uart_tx.sv
// Self-checking bench for adc_uart_tx: a CLK_DIV=4 instance for the functional
// and corner cases, plus a CLK_DIV=868 instance for full-rate bit timing.
module tb_adc_uart_tx;

    localparam int DA = 4;
    localparam int DB = 868;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, eoconv, clr, sel;
    logic [11:0] din;
    logic        eoconv_a, eoconv_b;
    logic        tx_a, busy_a, eotx_a, ovr_a;
    logic        tx_b, busy_b, eotx_b, ovr_b;
    logic        tx_m, busy_m, eotx_m, ovr_m;

    assign eoconv_a = sel ? 1'b0 : eoconv;
    assign eoconv_b = sel ? eoconv : 1'b0;
    assign tx_m   = sel ? tx_b   : tx_a;
    assign busy_m = sel ? busy_b : busy_a;
    assign eotx_m = sel ? eotx_b : eotx_a;
    assign ovr_m  = sel ? ovr_b  : ovr_a;

    adc_uart_tx #(.CLK_DIV(DA), .HDR(4'hA)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .eoconv_i(eoconv_a), .din_i(din), .clr_i(clr),
        .tx_o(tx_a), .busy_o(busy_a), .eotx_o(eotx_a), .ovr_o(ovr_a)
    );

    adc_uart_tx #(.CLK_DIV(DB), .HDR(4'hA)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .eoconv_i(eoconv_b), .din_i(din), .clr_i(clr),
        .tx_o(tx_b), .busy_o(busy_b), .eotx_o(eotx_b), .ovr_o(ovr_b)
    );

    typedef struct {
        logic [11:0] din;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called on a negedge; the sample is captured on the following posedge.
    task automatic send(input logic [11:0] d);
        eoconv = 1'b1;
        din    = d;
        @(negedge clk);
        eoconv = 1'b0;
        din    = 12'h555;
    endtask

    // Entered on the negedge just after the capture edge. Checks every cycle of
    // the 20 bit periods, optionally injects a late sample at cycle inj, and
    // ends on the negedge after the completion edge.
    task automatic run_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input int div, input int inj, input logic [11:0] inj_din,
                             input logic ovr0);
        logic [19:0] fb;
        int          bad [20];
        int          bad_busy, bad_ovr;
        logic        exp_ovr;
        fb[0]  = 1'b0;
        fb[9]  = 1'b1;
        fb[10] = 1'b0;
        fb[19] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fb[1 + i]  = b0[i];
            fb[11 + i] = b1[i];
        end
        for (int k = 0; k < 20; k++) bad[k] = 0;
        bad_busy = 0;
        bad_ovr  = 0;
        for (int c = 0; c < 20 * div; c++) begin
            if (c > 0) @(negedge clk);
            if (tx_m !== fb[c / div]) bad[c / div]++;
            if (busy_m !== 1'b1 || eotx_m !== 1'b0) bad_busy++;
            exp_ovr = ovr0 || (inj >= 0 && c > inj);
            if (ovr_m !== exp_ovr) bad_ovr++;
            if (c == inj) begin
                eoconv = 1'b1;
                din    = inj_din;
            end else if (c == inj + 1) begin
                eoconv = 1'b0;
            end
        end
        @(negedge clk);
        eoconv = 1'b0;
        for (int k = 0; k < 20; k++) check($sformatf("%s bit%0d", tag, k), bad[k], 0);
        check({tag, " busy/eotx in frame"}, bad_busy, 0);
        check({tag, " ovr in frame"}, bad_ovr, 0);
        check({tag, " eotx at end"}, eotx_m, 1);
        check({tag, " busy at end"}, busy_m, 0);
        check({tag, " tx at end"}, tx_m, 1);
        check({tag, " ovr at end"}, ovr_m, ovr0 || (inj >= 0));
    endtask

    task automatic idle_check(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx_m !== 1'b1 || busy_m !== 1'b0 || eotx_m !== 1'b0) bad++;
        end
        check({tag, " stays idle"}, bad, 0);
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{12'h9B2, 8'hA9, 8'hB2};
        vecs[1] = '{12'h000, 8'hA0, 8'h00};
        vecs[2] = '{12'hFFF, 8'hAF, 8'hFF};
        vecs[3] = '{12'h123, 8'hA1, 8'h23};
        vecs[4] = '{12'h5A5, 8'hA5, 8'hA5};

        rst_n  = 1'b0;
        eoconv = 1'b0;
        clr    = 1'b0;
        sel    = 1'b0;
        din    = 12'h000;
        repeat (3) @(negedge clk);
        check("reset tx", tx_m, 1);
        check("reset busy", busy_m, 0);
        check("reset eotx", eotx_m, 0);
        check("reset ovr", ovr_m, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            send(vecs[v].din);
            run_frame($sformatf("vec%0d", v), vecs[v].b0, vecs[v].b1, DA, -1, 12'h000, 1'b0);
            repeat (2) @(negedge clk);
        end

        // Late sample mid-frame: dropped, flagged, frame unaffected, then cleared.
        send(12'h9B2);
        run_frame("ovr40", 8'hA9, 8'hB2, DA, 40, 12'h123, 1'b0);
        idle_check("ovr40", 12);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr clears ovr", ovr_m, 0);

        // Overrun and clear in the same cycle: set must win.
        send(12'h9B2);
        repeat (4) @(negedge clk);
        eoconv = 1'b1;
        @(negedge clk);
        eoconv = 1'b0;
        check("ovr set mid-frame", ovr_m, 1);
        repeat (4) @(negedge clk);
        eoconv = 1'b1;
        clr    = 1'b1;
        @(negedge clk);
        eoconv = 1'b0;
        clr    = 1'b0;
        check("set beats clr", ovr_m, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr mid-frame", ovr_m, 0);
        repeat (80 - 11) @(negedge clk);
        check("collision frame eotx", eotx_m, 1);
        check("collision frame busy", busy_m, 0);
        repeat (2) @(negedge clk);

        // Sample in the eotx cycle starts the next frame with no idle gap.
        send(12'h9B2);
        run_frame("b2b first", 8'hA9, 8'hB2, DA, -1, 12'h000, 1'b0);
        send(12'hFFF);
        run_frame("b2b second", 8'hAF, 8'hFF, DA, -1, 12'h000, 1'b0);
        repeat (2) @(negedge clk);

        // Sample in the very last STOP cycle is an overrun, not a new frame.
        send(12'h123);
        run_frame("last stop", 8'hA1, 8'h23, DA, 20 * DA - 1, 12'h456, 1'b0);
        idle_check("last stop", 12);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;

        // Asynchronous reset mid-frame, then a clean frame.
        send(12'h9B2);
        repeat (29) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst tx", tx_m, 1);
        check("async rst busy", busy_m, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post rst ovr", ovr_m, 0);
        send(12'h000);
        run_frame("after rst", 8'hA0, 8'h00, DA, -1, 12'h000, 1'b0);

        // Full-rate divider: every bit exactly 868 cycles, 17360-cycle frame.
        sel = 1'b1;
        repeat (2) @(negedge clk);
        check("div868 idle tx", tx_m, 1);
        send(12'h5A5);
        run_frame("div868", 8'hA5, 8'hA5, DB, -1, 12'h000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
